// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write scheduler.
// The init table length and hold width are sized for the fixed power-up sequence.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        SETUP,
        EN,
        HOLD,
        IDLE
    } state_t;

    localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
    localparam logic [7:0] DISP_ON       = 8'h0C;
    localparam logic [7:0] CLEAR         = 8'h01;
    localparam logic [7:0] HOME          = 8'h02;
    localparam logic [7:0] ENTRY_INC     = 8'h06;

    localparam logic [2:0] INIT_LEN = 3'd7;

    // Clear and home need the long settle time; everything else holds one cycle.
    function automatic logic [7:0] hold_for(input logic is_cmd, input logic [7:0] b,
                                            input logic [7:0] clear_h);
        return (is_cmd && (b == CLEAR || b == HOME)) ? clear_h : 8'd1;
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Power-up command table: index -> {command byte, E-low hold cycles}.
import lcd_pkg::*;

module lcd_init_rom #(
    parameter int CLEAR_MS = 2
) (
    input  logic [2:0] i_idx,
    output logic [7:0] o_cmd,
    output logic [7:0] o_hold
);

    always_comb begin
        o_cmd  = FUNC_SET_8B2L;
        o_hold = 8'd1;
        case (i_idx)
            3'd0: o_hold = 8'd5;
            3'd4: o_cmd = DISP_ON;
            3'd5: begin
                o_cmd  = CLEAR;
                o_hold = 8'(CLEAR_MS);
            end
            3'd6: o_cmd = ENTRY_INC;
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_write_sched.sv
// Character-LCD sequencer: power-up init, then two-port arbitration of byte writes
// turned into timed E/RS/DB cycles on the 1 ms clock.
import lcd_pkg::*;

module lcd_write_sched #(
    parameter int POWERUP_MS = 20,
    parameter int CLEAR_MS   = 2,
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk_1ms,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_cmd,
    input  logic [15:0] req_byte,
    output logic [1:0]  req_ack,
    output logic        E,
    output logic        RW,
    output logic        RS,
    output logic [7:0]  DB,
    output logic        busy,
    output logic        init_done
);

    localparam logic [15:0] PWR_CNT = 16'(POWERUP_MS);
    localparam logic [7:0]  CLEAR_H = 8'(CLEAR_MS);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_hold;
    logic        r_last;
    logic [1:0]  r_ack;
    logic        r_e;
    logic        r_rs;
    logic [7:0]  r_db;
    logic        r_busy;
    logic        r_init_done;

    logic [7:0]  w_rom_cmd;
    logic [7:0]  w_rom_hold;
    logic        w_win;
    logic        w_any;
    logic [7:0]  w_sel_byte;
    logic        w_sel_cmd;
    logic        w_done_hold;
    logic        w_load_rom;
    logic        w_serve;

    lcd_init_rom #(.CLEAR_MS(CLEAR_MS)) u_rom (
        .i_idx  (r_idx),
        .o_cmd  (w_rom_cmd),
        .o_hold (w_rom_hold)
    );

    // Tie-break: fixed priority favours port 0, round-robin favours the port not granted last.
    always_comb begin
        w_win = 1'b0;
        if (req_valid == 2'b10)
            w_win = 1'b1;
        else if (req_valid == 2'b11 && FIXED_PRIO == 0 && r_last == 1'b0)
            w_win = 1'b1;
    end

    assign w_any      = |req_valid;
    assign w_sel_byte = w_win ? req_byte[15:8] : req_byte[7:0];
    assign w_sel_cmd  = req_cmd[w_win];

    // A finishing write doubles as an IDLE edge so back-to-back grants are 3 cycles apart.
    assign w_done_hold = (r_state == HOLD) && (r_cnt == 16'd0);
    assign w_load_rom  = ((r_state == PWR_WAIT) && (r_cnt == PWR_CNT)) ||
                         (w_done_hold && !r_init_done && (r_idx != INIT_LEN));
    assign w_serve     = (r_state == IDLE) || (w_done_hold && !w_load_rom);

    always_ff @(posedge clk_1ms or posedge reset) begin
        if (reset) begin
            r_state     <= PWR_WAIT;
            r_cnt       <= 16'd0;
            r_idx       <= 3'd0;
            r_hold      <= 8'd1;
            r_last      <= 1'b1;
            r_ack       <= 2'b00;
            r_e         <= 1'b0;
            r_rs        <= 1'b0;
            r_db        <= 8'h00;
            r_busy      <= 1'b1;
            r_init_done <= 1'b0;
        end else begin
            r_ack <= 2'b00;
            if (w_load_rom) begin
                r_db    <= w_rom_cmd;
                r_rs    <= 1'b0;
                r_e     <= 1'b0;
                r_hold  <= w_rom_hold;
                r_idx   <= r_idx + 3'd1;
                r_busy  <= 1'b1;
                r_state <= SETUP;
            end else if (w_serve) begin
                r_init_done <= 1'b1;
                r_e         <= 1'b0;
                if (w_any) begin
                    r_ack[w_win] <= 1'b1;
                    r_last       <= w_win;
                    r_db         <= w_sel_byte;
                    r_rs         <= ~w_sel_cmd;
                    r_hold       <= hold_for(w_sel_cmd, w_sel_byte, CLEAR_H);
                    r_busy       <= 1'b1;
                    r_state      <= SETUP;
                end else begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            end else begin
                case (r_state)
                    PWR_WAIT: r_cnt <= r_cnt + 16'd1;
                    SETUP: begin
                        r_e     <= 1'b1;
                        r_state <= EN;
                    end
                    EN: begin
                        r_e     <= 1'b0;
                        r_cnt   <= {8'd0, r_hold} - 16'd1;
                        r_state <= HOLD;
                    end
                    HOLD: r_cnt <= r_cnt - 16'd1;
                    default: ;
                endcase
            end
        end
    end

    assign req_ack   = r_ack;
    assign E         = r_e;
    assign RW        = 1'b0;
    assign RS        = r_rs;
    assign DB        = r_db;
    assign busy      = r_busy;
    assign init_done = r_init_done;

endmodule

// File: tb/tb_lcd_write_sched.sv
// Scoreboard bench for lcd_write_sched: expected {RS,DB} pushed at request time,
// popped on each rising E.
module tb_lcd_write_sched;

    logic        clk_1ms = 1'b0;
    logic        reset   = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_cmd   = 2'b00;
    logic [15:0] req_byte  = 16'h0000;
    logic [1:0]  req_ack;
    logic        E, RW, RS, busy, init_done;
    logic [7:0]  DB;

    int n_total = 0;
    int n_bad   = 0;
    int ecnt    = 0;
    int n_rise  = 0;
    int last_rise = 0;
    logic prev_e = 1'b0;
    logic [8:0] sbq[$];

    lcd_write_sched #(.POWERUP_MS(20), .CLEAR_MS(2), .FIXED_PRIO(0)) dut (
        .clk_1ms   (clk_1ms),
        .reset     (reset),
        .req_valid (req_valid),
        .req_cmd   (req_cmd),
        .req_byte  (req_byte),
        .req_ack   (req_ack),
        .E         (E),
        .RW        (RW),
        .RS        (RS),
        .DB        (DB),
        .busy      (busy),
        .init_done (init_done)
    );

    always #5 clk_1ms = ~clk_1ms;

    always @(posedge clk_1ms or posedge reset) begin
        if (reset) ecnt <= 0;
        else       ecnt <= ecnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (edge %0d)", tag, got, want, ecnt);
        end
    endtask

    always @(negedge clk_1ms) begin
        if (!reset) begin
            if (E && !prev_e) begin
                n_rise++;
                last_rise = ecnt;
                if (sbq.size() == 0) chk("extra_e_pulse", 1, 0);
                else chk("write_rs_db", {23'd0, RS, DB}, {23'd0, sbq.pop_front()});
            end
            if (req_ack != 2'b00) chk("ack_before_init", {31'd0, init_done}, 1);
            chk("rw_low", {31'd0, RW}, 0);
        end
        prev_e = E;
    end

    task automatic step();
        @(negedge clk_1ms);
        #1;
    endtask

    task automatic push_init();
        logic [7:0] tbl [7];
        tbl = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        for (int i = 0; i < 7; i++) sbq.push_back({1'b0, tbl[i]});
    endtask

    task automatic wait_rise(input int budget, output int edge_no);
        int n0 = n_rise;
        edge_no = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (n_rise > n0) begin
                edge_no = last_rise;
                return;
            end
        end
        chk("rise_timeout", 0, 1);
    endtask

    task automatic wait_init(input int budget, output int edge_no);
        edge_no = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (init_done) begin
                edge_no = ecnt;
                return;
            end
        end
        chk("init_timeout", 0, 1);
    endtask

    task automatic wait_ack(input int budget, output logic [1:0] a, output int edge_no);
        a = 2'b00;
        edge_no = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (req_ack != 2'b00) begin
                a = req_ack;
                edge_no = ecnt;
                return;
            end
        end
        chk("ack_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) return;
            step();
        end
        chk("idle_timeout", 0, 1);
    endtask

    initial begin
        logic [1:0] a;
        int ed, ea, eb, nr0, nacks;

        #1 reset = 1'b1;
        #2;
        chk("rst_e", {31'd0, E}, 0);
        chk("rst_rs_db", {23'd0, RS, DB}, 0);
        chk("rst_ack", {30'd0, req_ack}, 0);
        chk("rst_busy_initdone", {30'd0, busy, init_done}, 2'b10);
        push_init();
        repeat (3) step();
        reset = 1'b0;

        // Port 1 requests during init; must wait for init completion.
        for (int i = 0; i < 10 && ecnt < 4; i++) step();
        req_valid[1] = 1'b1; req_cmd[1] = 1'b0; req_byte[15:8] = 8'h41;
        sbq.push_back({1'b1, 8'h41});
        wait_rise(40, ed);
        chk("first_e_edge", ed, 22);
        wait_init(60, ed);
        chk("init_done_edge", ed, 47);
        chk("init_ack_p1", {30'd0, req_ack}, 2'b10);
        req_valid[1] = 1'b0;
        wait_rise(5, ed);
        chk("char_e_edge", ed, 48);
        chk("rise_count_init", n_rise, 8);

        // Tie with port 1 granted last: port 0 first, then port 1 three edges later.
        wait_idle(10);
        req_valid = 2'b11; req_cmd = 2'b00; req_byte = {8'h32, 8'h31};
        sbq.push_back({1'b1, 8'h31}); sbq.push_back({1'b1, 8'h32});
        wait_ack(10, a, ea);
        chk("tie1_first", {30'd0, a}, 2'b01);
        req_valid[0] = 1'b0;
        wait_ack(10, a, eb);
        chk("tie1_second", {30'd0, a}, 2'b10);
        chk("tie1_spacing", eb - ea, 3);
        req_valid[1] = 1'b0;

        // Port 0 granted last, so the next tie goes to port 1.
        wait_idle(10);
        req_valid = 2'b01; req_byte[7:0] = 8'h50;
        sbq.push_back({1'b1, 8'h50});
        wait_ack(10, a, ea);
        chk("solo_p0", {30'd0, a}, 2'b01);
        req_valid = 2'b00;
        wait_idle(10);
        req_valid = 2'b11; req_byte = {8'h34, 8'h33};
        sbq.push_back({1'b1, 8'h34}); sbq.push_back({1'b1, 8'h33});
        wait_ack(10, a, ea);
        chk("tie2_first", {30'd0, a}, 2'b10);
        req_valid[1] = 1'b0;
        wait_ack(10, a, eb);
        chk("tie2_second", {30'd0, a}, 2'b01);
        req_valid[0] = 1'b0;

        // Clear command: one E-high cycle, two E-low hold cycles, next grant 4 edges later.
        wait_idle(10);
        req_valid = 2'b01; req_cmd = 2'b01; req_byte[7:0] = 8'h01;
        sbq.push_back({1'b0, 8'h01});
        wait_ack(10, a, ea);
        chk("clr_ack", {30'd0, a}, 2'b01);
        req_valid = 2'b10; req_cmd = 2'b00; req_byte[15:8] = 8'h35;
        sbq.push_back({1'b1, 8'h35});
        step(); chk("clr_e_high", {31'd0, E}, 1);
        step(); chk("clr_e_low1", {31'd0, E}, 0);
        step(); chk("clr_e_low2", {31'd0, E}, 0);
        wait_ack(10, a, eb);
        chk("clr_next_ack", {30'd0, a}, 2'b10);
        chk("clr_spacing", eb - ea, 4);
        req_valid = 2'b00;

        // Reset between SETUP and EN aborts the write immediately.
        wait_idle(10);
        req_valid = 2'b01; req_byte[7:0] = 8'h55;
        sbq.push_back({1'b1, 8'h55});
        wait_ack(10, a, ea);
        reset = 1'b1;
        #1;
        chk("mid_rst_e", {31'd0, E}, 0);
        chk("mid_rst_rs_db", {23'd0, RS, DB}, 0);
        chk("mid_rst_ack", {30'd0, req_ack}, 0);
        chk("mid_rst_busy_initdone", {30'd0, busy, init_done}, 2'b10);
        req_valid = 2'b00;
        sbq.delete();
        push_init();
        repeat (2) step();
        reset = 1'b0;
        wait_rise(40, ed);
        chk("restart_first_e", ed, 22);
        wait_init(60, ed);
        chk("restart_init_done", ed, 47);

        // Withdrawn request during a write: no ack, no extra E pulse.
        wait_idle(10);
        nr0 = n_rise;
        req_valid = 2'b10; req_byte[15:8] = 8'h61;
        sbq.push_back({1'b1, 8'h61});
        wait_ack(10, a, ea);
        chk("wd_p1_ack", {30'd0, a}, 2'b10);
        req_valid = 2'b01; req_byte[7:0] = 8'h62;
        step();
        req_valid = 2'b00;
        nacks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (req_ack != 2'b00) nacks++;
        end
        chk("wd_no_ack", nacks, 0);
        chk("wd_one_pulse", n_rise - nr0, 1);
        chk("sb_left", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1);
    end

endmodule
